ninjin_ddr_sched: RTL and testbench

Sequencing front-end for the ninjin image DMA master, which exposes the `ddr_req`/`ddr_mode`/`ddr_base`/`ddr_len` command port. It round-robin arbitrates `NREQ` transfer requesters and splits each transfer into AXI-legal bursts: at most `BURST_MAX` beats, never crossing a 4 KB boundary. It issues one burst at a time and waits for the engine's completion pulse before issuing the next. Per-requester accept, done and error are returned to the requesters.

---
 rtl/ninjin_ddr_sched_pkg.sv | 36 +++
 rtl/ninjin_ddr_sched_rr_arbiter.sv | 40 ++++
 rtl/ninjin_ddr_sched.sv | 179 +++++++++++++++++
 tb/tb_ninjin_ddr_sched.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/ninjin_ddr_sched_pkg.sv
// Shared constants, scheduler state encoding and burst-length helper for the
// ninjin DDR command scheduler.
package ninjin_ddr_sched_pkg;

  localparam logic DDR_READ   = 1'b0;
  localparam logic DDR_WRITE  = 1'b1;
  localparam int   BWIDTH     = 32;                   // data bus width in bits
  localparam int   LSB        = $clog2(BWIDTH / 8);   // byte-address bits below a word
  localparam int   MEMSIZE    = 30;                   // word-address width
  localparam int   LWIDTH     = 9;                    // burst length field, holds 256
  localparam int   AWIDTH     = MEMSIZE + LSB;        // byte-address width
  localparam int   PAGE_BYTES = 4096;                 // AXI bursts may not cross this

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } sched_state_e;

  // Longest legal burst from the current position: limited by the words left,
  // the burst cap, and the words remaining before the next 4 KB page.
  function automatic logic [LWIDTH-1:0] burst_len(input logic [31:0] rem,
                                                 input logic [11:0] page_off,
                                                 input logic [31:0] burst_max);
    logic [31:0] bnd;
    logic [31:0] len;
    bnd = (32'(PAGE_BYTES) - {20'd0, page_off}) >> LSB;
    len = rem;
    if (len > burst_max) len = burst_max;
    if (len > bnd)       len = bnd;
    return LWIDTH'(len);
  endfunction

endpackage

// File: rtl/ninjin_ddr_sched_rr_arbiter.sv
// Round-robin arbiter: grants the first valid requester after the last one
// granted; the pointer only moves when the parent accepts the grant.
module ninjin_rr_arbiter #(
  parameter int NREQ = 3,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic            clk,
  input  logic            xrst,
  input  logic [NREQ-1:0] valid,
  input  logic            update,
  output logic [IW-1:0]   grant_idx,
  output logic            grant_valid
);

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] ptr_d;
  int            j;

  // Circular search starting one past the pointer; the pointer itself is last.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    j           = 0;
    for (int i = 1; i <= NREQ; i++) begin
      j = (int'(ptr_q) + i) % NREQ;
      if (!grant_valid && valid[j]) begin
        grant_valid = 1'b1;
        grant_idx   = IW'(j);
      end
    end
    ptr_d = update ? grant_idx : ptr_q;
  end

  // Pointer register; reset to the last index so requester 0 wins first.
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) ptr_q <= IW'(NREQ - 1);
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/ninjin_ddr_sched.sv
// DDR command scheduler: arbitrates requesters, splits each transfer into
// bursts of at most BURST_MAX beats that never cross a 4 KB page, and issues
// them one at a time, waiting for the engine's completion pulse in between.
module ninjin_ddr_sched
  import ninjin_ddr_sched_pkg::*;
#(
  parameter int NREQ      = 3,
  parameter int BURST_MAX = 256,
  parameter int TWIDTH    = 20
) (
  input  logic                   clk,
  input  logic                   xrst,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ-1:0]        req_mode,
  input  logic [NREQ*AWIDTH-1:0] req_base,
  input  logic [NREQ*TWIDTH-1:0] req_total,
  input  logic                   ddr_done,
  input  logic [3:0]             ddr_err,
  output logic [NREQ-1:0]        req_ack,
  output logic [NREQ-1:0]        req_done,
  output logic [NREQ-1:0]        req_err,
  output logic [3:0]             err_code,
  output logic                   busy,
  output logic                   ddr_req,
  output logic                   ddr_mode,
  output logic [AWIDTH-1:0]      ddr_base,
  output logic [LWIDTH-1:0]      ddr_len
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  sched_state_e      state_q, state_d;
  logic [IW-1:0]     sel_q, sel_d;
  logic              mode_q, mode_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [TWIDTH-1:0] rem_q, rem_d;
  logic              ddr_req_q, ddr_req_d;
  logic              ddr_mode_q, ddr_mode_d;
  logic [AWIDTH-1:0] ddr_base_q, ddr_base_d;
  logic [LWIDTH-1:0] ddr_len_q, ddr_len_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic [NREQ-1:0]   rerr_q, rerr_d;
  logic [3:0]        err_code_q, err_code_d;
  logic              busy_q, busy_d;

  logic [IW-1:0]     grant_idx;
  logic              grant_valid;
  logic              arb_update;
  logic [NREQ-1:0]   sel_oh;

  ninjin_rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
    .clk         (clk),
    .xrst        (xrst),
    .valid       (req_valid),
    .update      (arb_update),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  assign sel_oh = NREQ'(1) << sel_q;

  // Next-state and registered-output logic of the burst sequencer.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    mode_d     = mode_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    ddr_req_d  = 1'b0;
    ddr_mode_d = ddr_mode_q;
    ddr_base_d = ddr_base_q;
    ddr_len_d  = ddr_len_q;
    ack_d      = '0;
    done_d     = '0;
    rerr_d     = '0;
    err_code_d = err_code_q;
    arb_update = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (grant_valid) begin
          arb_update = 1'b1;
          sel_d      = grant_idx;
          mode_d     = req_mode[grant_idx];
          addr_d     = req_base[grant_idx*AWIDTH +: AWIDTH];
          rem_d      = req_total[grant_idx*TWIDTH +: TWIDTH];
          ack_d      = NREQ'(1) << grant_idx;
          err_code_d = '0;
          state_d    = S_CALC;
        end
      end
      S_CALC: begin
        // Only a zero-length request reaches here with nothing left to move.
        if (rem_q == '0) begin
          done_d  = sel_oh;
          state_d = S_DONE;
        end else begin
          ddr_base_d = addr_q;
          ddr_len_d  = burst_len(32'(rem_q), addr_q[11:0], 32'(BURST_MAX));
          ddr_mode_d = mode_q;
          ddr_req_d  = 1'b1;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // Address wraps silently at the top of the address space.
        addr_d  = addr_q + (AWIDTH'(ddr_len_q) << LSB);
        rem_d   = rem_q - TWIDTH'(ddr_len_q);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (ddr_done) begin
          if (ddr_err != 4'd0) err_code_d = ddr_err;
          if (ddr_err[0]) begin
            done_d  = sel_oh;
            rerr_d  = sel_oh;
            state_d = S_DONE;
          end else if (rem_q == '0) begin
            done_d  = sel_oh;
            state_d = S_DONE;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset abandons any transfer in flight.
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      state_q    <= S_IDLE;
      sel_q      <= '0;
      mode_q     <= 1'b0;
      addr_q     <= '0;
      rem_q      <= '0;
      ddr_req_q  <= 1'b0;
      ddr_mode_q <= 1'b0;
      ddr_base_q <= '0;
      ddr_len_q  <= '0;
      ack_q      <= '0;
      done_q     <= '0;
      rerr_q     <= '0;
      err_code_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      mode_q     <= mode_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      ddr_req_q  <= ddr_req_d;
      ddr_mode_q <= ddr_mode_d;
      ddr_base_q <= ddr_base_d;
      ddr_len_q  <= ddr_len_d;
      ack_q      <= ack_d;
      done_q     <= done_d;
      rerr_q     <= rerr_d;
      err_code_q <= err_code_d;
      busy_q     <= busy_d;
    end
  end

  assign req_ack  = ack_q;
  assign req_done = done_q;
  assign req_err  = rerr_q;
  assign err_code = err_code_q;
  assign busy     = busy_q;
  assign ddr_req  = ddr_req_q;
  assign ddr_mode = ddr_mode_q;
  assign ddr_base = ddr_base_q;
  assign ddr_len  = ddr_len_q;

endmodule

// File: tb/tb_ninjin_ddr_sched.sv
// Directed bench for ninjin_ddr_sched: single burst, splitting, 4 KB page
// split, error abort, zero length, round-robin order and async reset.
module tb_ninjin_ddr_sched;
  import ninjin_ddr_sched_pkg::*;

  localparam int NREQ = 3;
  localparam int TW   = 20;
  localparam int AW   = AWIDTH;

  logic                clk = 1'b0;
  logic                xrst = 1'b0;
  logic [NREQ-1:0]     req_valid = '0;
  logic [NREQ-1:0]     req_mode = '0;
  logic [NREQ*AW-1:0]  req_base = '0;
  logic [NREQ*TW-1:0]  req_total = '0;
  logic                ddr_done = 1'b0;
  logic [3:0]          ddr_err = '0;
  logic [NREQ-1:0]     req_ack;
  logic [NREQ-1:0]     req_done;
  logic [NREQ-1:0]     req_err;
  logic [3:0]          err_code;
  logic                busy;
  logic                ddr_req;
  logic                ddr_mode;
  logic [AW-1:0]       ddr_base;
  logic [LWIDTH-1:0]   ddr_len;

  int checks = 0;
  int failures = 0;
  int req_cnt = 0;
  int done_cnt = 0;
  bit ack_multi = 1'b0;
  int c0;

  ninjin_ddr_sched #(.NREQ(NREQ), .BURST_MAX(256), .TWIDTH(TW)) dut (
    .clk       (clk),
    .xrst      (xrst),
    .req_valid (req_valid),
    .req_mode  (req_mode),
    .req_base  (req_base),
    .req_total (req_total),
    .ddr_done  (ddr_done),
    .ddr_err   (ddr_err),
    .req_ack   (req_ack),
    .req_done  (req_done),
    .req_err   (req_err),
    .err_code  (err_code),
    .busy      (busy),
    .ddr_req   (ddr_req),
    .ddr_mode  (ddr_mode),
    .ddr_base  (ddr_base),
    .ddr_len   (ddr_len)
  );

  always #5 clk = ~clk;

  // Strobe counters and simultaneous-ack detector.
  always @(posedge clk) begin
    if (ddr_req) req_cnt++;
    if (|req_done) done_cnt++;
    if (!$onehot0(req_ack)) ack_multi = 1'b1;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Present a request for one sample, then check the ack in the following cycle.
  task automatic start(input int idx, input logic m, input logic [31:0] b, input int t);
    req_mode[idx]          = m;
    req_base[idx*AW +: AW] = b;
    req_total[idx*TW +: TW] = TW'(t);
    req_valid[idx]         = 1'b1;
    step();
    check_eq("req_ack", 64'(req_ack), 64'(1 << idx));
    req_valid[idx] = 1'b0;
  endtask

  // Wait for the next strobe, check the command, then complete it two cycles later.
  task automatic do_burst(input logic [31:0] eb, input int el, input logic em, input logic [3:0] err);
    int n;
    n = 0;
    while (ddr_req !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    if (n >= 20) begin
      check_eq("burst_timeout", 64'(0), 64'(1));
      return;
    end
    check_eq("ddr_base", 64'(ddr_base), 64'(eb));
    check_eq("ddr_len", 64'(ddr_len), 64'(el));
    check_eq("ddr_mode", 64'(ddr_mode), 64'(em));
    step();
    check_eq("ddr_req_pulse", 64'(ddr_req), 64'(0));
    step();
    ddr_done = 1'b1;
    ddr_err  = err;
    step();
    ddr_done = 1'b0;
    ddr_err  = '0;
  endtask

  task automatic finish_chk(input int idx, input logic e);
    check_eq("req_done", 64'(req_done), 64'(1 << idx));
    check_eq("req_err", 64'(req_err), e ? 64'(1 << idx) : 64'(0));
    step();
    check_eq("idle_busy", 64'(busy), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) step();
    check_eq("rst_busy", 64'(busy), 64'(0));
    check_eq("rst_ddr_req", 64'(ddr_req), 64'(0));
    check_eq("rst_ddr_base", 64'(ddr_base), 64'(0));
    check_eq("rst_ddr_len", 64'(ddr_len), 64'(0));
    check_eq("rst_req_ack", 64'(req_ack), 64'(0));
    check_eq("rst_err_code", 64'(err_code), 64'(0));
    xrst = 1'b1;
    step();

    // Single request.
    start(0, DDR_READ, 32'h1000, 16);
    check_eq("busy_calc", 64'(busy), 64'(1));
    do_burst(32'h1000, 16, DDR_READ, 4'd0);
    finish_chk(0, 1'b0);

    // Split by burst cap.
    start(0, DDR_WRITE, 32'h0, 600);
    do_burst(32'h0000, 256, DDR_WRITE, 4'd0);
    do_burst(32'h0400, 256, DDR_WRITE, 4'd0);
    do_burst(32'h0800, 88, DDR_WRITE, 4'd0);
    finish_chk(0, 1'b0);

    // Split at the 4 KB page.
    start(0, DDR_READ, 32'h0F80, 100);
    do_burst(32'h0F80, 32, DDR_READ, 4'd0);
    do_burst(32'h1000, 68, DDR_READ, 4'd0);
    finish_chk(0, 1'b0);

    // Error on the first burst aborts the transfer.
    start(1, DDR_WRITE, 32'h0, 600);
    do_burst(32'h0000, 256, DDR_WRITE, 4'b0101);
    c0 = req_cnt;
    finish_chk(1, 1'b1);
    check_eq("err_code", 64'(err_code), 64'(4'b0101));
    repeat (4) step();
    check_eq("err_no_more_req", 64'(req_cnt - c0), 64'(0));
    check_eq("err_code_held", 64'(err_code), 64'(4'b0101));

    // Zero-length request: ack then done, no command.
    c0 = req_cnt;
    start(2, DDR_READ, 32'h100, 0);
    check_eq("err_code_cleared", 64'(err_code), 64'(0));
    step();
    finish_chk(2, 1'b0);
    check_eq("zero_no_req", 64'(req_cnt - c0), 64'(0));

    // Round-robin between two continuously valid requesters.
    req_mode  = '0;
    req_base[0*AW +: AW]  = 32'h2000;
    req_base[1*AW +: AW]  = 32'h3000;
    req_total[0*TW +: TW] = TW'(4);
    req_total[1*TW +: TW] = TW'(4);
    req_valid = 3'b011;
    for (int i = 0; i < 4; i++) begin
      int n;
      n = 0;
      while (req_ack == '0 && n < 10) begin
        step();
        n++;
      end
      check_eq("rr_ack", 64'(req_ack), 64'(1 << (i % 2)));
      do_burst((i % 2 == 1) ? 32'h3000 : 32'h2000, 4, DDR_READ, 4'd0);
      if (i == 3) req_valid = '0;
      finish_chk(i % 2, 1'b0);
    end
    check_eq("ack_onehot", 64'(ack_multi), 64'(0));

    // Asynchronous reset during S_WAIT.
    start(0, DDR_WRITE, 32'h1000, 16);
    step();
    check_eq("pre_rst_req", 64'(ddr_req), 64'(1));
    step();
    c0 = done_cnt;
    #2 xrst = 1'b0;
    #1;
    check_eq("arst_busy", 64'(busy), 64'(0));
    check_eq("arst_ddr_base", 64'(ddr_base), 64'(0));
    check_eq("arst_ddr_len", 64'(ddr_len), 64'(0));
    check_eq("arst_ddr_mode", 64'(ddr_mode), 64'(0));
    step();
    step();
    xrst = 1'b1;
    ddr_done = 1'b1;
    step();
    ddr_done = 1'b0;
    step();
    check_eq("arst_no_done", 64'(done_cnt - c0), 64'(0));
    check_eq("arst_idle", 64'(busy), 64'(0));

    // Pointer returned to its reset value: requester 0 wins over 1.
    req_base[0*AW +: AW]  = 32'h40;
    req_base[1*AW +: AW]  = 32'h80;
    req_total[0*TW +: TW] = TW'(4);
    req_total[1*TW +: TW] = TW'(4);
    req_mode  = '0;
    req_valid = 3'b011;
    step();
    check_eq("rst_ptr_ack", 64'(req_ack), 64'(3'b001));
    req_valid = '0;
    do_burst(32'h40, 4, DDR_READ, 4'd0);
    finish_chk(0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
